driver_keys: RTL and testbench
==============================

DRIVER_KEYS -- requirements
Module: driver_keys

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), range 2..65535; number of consecutive stable synchronized cycles required to accept a new input level.
REQ-002 clk  input  1  single system clock; all state SHALL be clocked on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 chip_select  input  1  peripheral selected for the current bus cycle.
REQ-005 write_enable  input  1  write strobe, qualified by chip_select.
REQ-006 address  input  2  register select: 0 SW_STATE, 1 KEY_STATE, 2 KEY_EDGE, 3 KEY_MASK.
REQ-007 data_write  input  32  write data.
REQ-008 data_read  output  32  registered read data.
REQ-009 sw  input  10  raw slide switches, active-high, asynchronous to clk.
REQ-010 key  input  4  raw pushbuttons, active-low (0 = pressed), asynchronous to clk.
REQ-011 irq  output  1  level interrupt, active-high.

Function
REQ-012 Each of the 14 raw inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per bit, a 16-bit debounce counter SHALL clear whenever the synchronized level equals the debounced level, and increment otherwise.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced level SHALL take the synchronized level on that edge and the counter SHALL clear.
REQ-015 A raw level held constant SHALL appear in the debounced state exactly DEBOUNCE_CYCLES+2 cycles after the first sampling edge; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced state.
REQ-016 Key state SHALL be reported active-high (1 = pressed), i.e. the debounced inverse of key.
REQ-017 KEY_EDGE[i] SHALL set on the same edge that debounced KEY_STATE[i] goes 0->1 (press); release SHALL NOT set it.
REQ-018 Writing address 2 SHALL clear each KEY_EDGE bit whose data_write bit is 1 (write-1-to-clear); a set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-019 Writing address 3 SHALL load KEY_MASK <= data_write[3:0]; writes to addresses 0 and 1 SHALL be ignored.
REQ-020 irq SHALL be a register equal to |(KEY_EDGE & KEY_MASK) from the previous cycle (one cycle after the edge bit or mask changes).
REQ-021 When chip_select=1, data_read SHALL load on the next edge: addr0 {22'b0,SW_STATE}, addr1 {28'b0,KEY_STATE}, addr2 {28'b0,KEY_EDGE}, addr3 {28'b0,KEY_MASK}; when chip_select=0, data_read SHALL hold.
REQ-022 A read of address 2 in the same cycle as a write-clear of address 2 SHALL return the pre-clear value.
REQ-023 Counters SHALL saturate logic at DEBOUNCE_CYCLES-1 and never wrap.

Reset
REQ-024 On reset_n=0, asynchronously: data_read=0, irq=0, KEY_EDGE=0, KEY_MASK=0, SW_STATE=0, KEY_STATE=0, all counters=0.
REQ-025 Synchronizer flops SHALL reset to the "inactive" raw level: sw bits to 0, key bits to 1.
REQ-026 Inputs already active at reset release SHALL be reported only after the normal debounce latency; a key held through reset SHALL set KEY_EDGE once accepted.

Structure
REQ-027 A shared package driver_pkg SHALL hold register address constants (ADDR_SW_STATE..ADDR_KEY_MASK), NUM_SW=10, NUM_KEY=4, and the DEBOUNCE_CYCLES default.
REQ-028 A sub-module debounce_bit (synchronizer + counter + debounced flop, parameterized by DEBOUNCE_CYCLES and reset level) SHALL be instantiated 14 times.

Verification (run with DEBOUNCE_CYCLES=4)
REQ-029 sw=10'h2A5 held from cycle 0 -> SW_STATE=10'h2A5 on cycle 6; read addr0 -> data_read=32'h000002A5 one cycle later.
REQ-030 key[1] pulses low for 3 cycles -> KEY_STATE, KEY_EDGE, irq unchanged (all 0).
REQ-031 KEY_MASK=4'h2, key[1] held low -> KEY_STATE=4'h2 and KEY_EDGE=4'h2 on the same edge, irq=1 one cycle later; write 32'h2 to addr2 -> KEY_EDGE=0, irq=0 the following cycle.
REQ-032 Write-clear addr2 on the exact edge a new press of key[0] is accepted -> KEY_EDGE[0]=1 afterwards.
REQ-033 reset_n asserted mid-debounce (counter=2) -> all outputs 0 immediately; after release, the held input needs the full 6 cycles again.
REQ-034 Write 32'hFFFFFFFF to addr0/addr1 -> no state change; read addr3 after writing 32'hF -> data_read=32'h0000000F.

Source files
------------

// File: rtl/driver_keys_pkg.sv
// driver_pkg: register map and sizing shared by the switch/key peripheral.
package driver_pkg;

    localparam int NUM_SW = 10;
    localparam int NUM_KEY = 4;
    localparam int DEBOUNCE_DEFAULT = 50000;

    localparam logic [1:0] ADDR_SW_STATE = 2'd0;
    localparam logic [1:0] ADDR_KEY_STATE = 2'd1;
    localparam logic [1:0] ADDR_KEY_EDGE = 2'd2;
    localparam logic [1:0] ADDR_KEY_MASK = 2'd3;

endpackage

// File: rtl/driver_keys_debounce.sv
// debounce_bit: 2-flop synchronizer plus counter that accepts a level after DEBOUNCE_CYCLES stable cycles.
module debounce_bit
    import driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic accept
);

    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync;
    logic [15:0] count;

    // accept is the one-cycle strobe on which level flips
    assign accept = (sync[1] != level) && (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {2{RESET_LEVEL}};
            count <= '0;
            level <= RESET_LEVEL;
        end else begin
            sync <= {sync[0], raw};
            count <= (sync[1] == level || accept) ? '0 : count + 16'd1;
            level <= accept ? sync[1] : level;
        end
    end

endmodule

// File: rtl/driver_keys.sv
// driver_keys: debounced slide switches and pushbuttons with press-edge latch, mask and level irq.
module driver_keys
    import driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chip_select,
    input  logic        write_enable,
    input  logic [1:0]  address,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_KEY-1:0] key,
    output logic        irq
);

    logic [NUM_SW-1:0] sw_state;
    logic [NUM_SW-1:0] unused_sw_accept;
    logic [NUM_KEY-1:0] key_level, key_accept, key_state, key_press;
    logic [NUM_KEY-1:0] key_edge, key_mask, edge_clear;
    logic [31:0] read_mux;
    logic write;
    logic unused_data;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_db (
            .clk(clk),
            .reset_n(reset_n),
            .raw(sw[i]),
            .level(sw_state[i]),
            .accept(unused_sw_accept[i])
        );
    end

    for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_db (
            .clk(clk),
            .reset_n(reset_n),
            .raw(key[i]),
            .level(key_level[i]),
            .accept(key_accept[i])
        );
    end

    // keys are active-low: a released key accepting a change is a press
    assign key_state = ~key_level;
    assign key_press = key_accept & key_level;
    assign write = chip_select & write_enable;
    assign edge_clear = (write && address == ADDR_KEY_EDGE) ? data_write[NUM_KEY-1:0] : '0;
    assign unused_data = &{1'b0, data_write[31:NUM_KEY]};

    always_comb begin
        read_mux = address == ADDR_SW_STATE  ? {22'b0, sw_state} :
                   address == ADDR_KEY_STATE ? {28'b0, key_state} :
                   address == ADDR_KEY_EDGE  ? {28'b0, key_edge} :
                                               {28'b0, key_mask};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_edge <= '0;
            key_mask <= '0;
            irq <= 1'b0;
            data_read <= '0;
        end else begin
            key_edge <= (key_edge & ~edge_clear) | key_press;
            key_mask <= (write && address == ADDR_KEY_MASK) ? data_write[NUM_KEY-1:0] : key_mask;
            irq <= |(key_edge & key_mask);
            data_read <= chip_select ? read_mux : data_read;
        end
    end

endmodule

// File: tb/tb_driver_keys.sv
// tb_driver_keys: directed and random stimulus against a cycle-level scoreboard model.
module tb_driver_keys;

    localparam int D = 4;
    localparam logic [13:0] INACT = {4'hF, 10'h000};

    typedef struct {
        logic [31:0] dr;
        logic irq;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic chip_select = 1'b0;
    logic write_enable = 1'b0;
    logic [1:0] address = 2'd0;
    logic [31:0] data_write = 32'd0;
    logic [9:0] sw = 10'd0;
    logic [3:0] key = 4'hF;
    logic [31:0] data_read;
    logic irq;

    int total = 0;
    int bad = 0;

    exp_t exp_q[$];
    logic [13:0] raw_q[$];
    logic [13:0] deb, dly;
    int streak[14];
    logic [3:0] m_edge, m_mask, ks_old, press;
    logic [31:0] m_dr;
    logic m_irq;

    driver_keys #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .chip_select(chip_select),
        .write_enable(write_enable),
        .address(address),
        .data_write(data_write),
        .data_read(data_read),
        .sw(sw),
        .key(key),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q = '{INACT, INACT};
        deb = INACT;
        foreach (streak[i]) streak[i] = 0;
        m_edge = '0;
        m_mask = '0;
        m_dr = '0;
        m_irq = 1'b0;
        exp_q.delete();
    endtask

    // an input level is accepted once it has disagreed with the accepted level for D cycles,
    // as seen two sampling edges late
    task automatic model_step();
        ks_old = ~deb[13:10];
        if (chip_select) begin
            case (address)
                2'd0: m_dr = {22'b0, deb[9:0]};
                2'd1: m_dr = {28'b0, ks_old};
                2'd2: m_dr = {28'b0, m_edge};
                default: m_dr = {28'b0, m_mask};
            endcase
        end
        m_irq = |(m_edge & m_mask);
        dly = raw_q[1];
        raw_q.push_front({key, sw});
        void'(raw_q.pop_back());
        for (int i = 0; i < 14; i++) begin
            streak[i] = (dly[i] != deb[i]) ? streak[i] + 1 : 0;
            if (streak[i] == D) begin
                deb[i] = dly[i];
                streak[i] = 0;
            end
        end
        press = ~deb[13:10] & ~ks_old;
        if (chip_select && write_enable && address == 2'd2) m_edge &= ~data_write[3:0];
        m_edge |= press;
        if (chip_select && write_enable && address == 2'd3) m_mask = data_write[3:0];
        exp_q.push_back('{m_dr, m_irq});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_data_read", data_read, e.dr);
                    chk("sb_irq", {31'b0, irq}, {31'b0, e.irq});
                end
            end
        end
    end

    task automatic tick(input logic cs, input logic we, input logic [1:0] a, input logic [31:0] wd);
        chip_select = cs;
        write_enable = we;
        address = a;
        data_write = wd;
        @(negedge clk);
    endtask

    initial begin
        int b;
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("reset_data_read", data_read, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        sw = 10'h2A5;
        repeat (6) tick(1'b1, 1'b0, 2'd0, 32'h0);
        chk("sw_before_latency", data_read, 32'h0);
        tick(1'b1, 1'b0, 2'd0, 32'h0);
        chk("sw_after_latency", data_read, 32'h000002A5);

        key = 4'b1101;
        repeat (3) tick(1'b1, 1'b0, 2'd1, 32'h0);
        key = 4'hF;
        repeat (8) tick(1'b1, 1'b0, 2'd1, 32'h0);
        chk("glitch_key_state", data_read, 32'h0);
        tick(1'b1, 1'b0, 2'd2, 32'h0);
        chk("glitch_key_edge", data_read, 32'h0);
        chk("glitch_irq", {31'b0, irq}, 32'h0);

        tick(1'b1, 1'b1, 2'd3, 32'h2);
        key = 4'b1101;
        repeat (5) tick(1'b1, 1'b0, 2'd1, 32'h0);
        tick(1'b1, 1'b0, 2'd2, 32'h0);
        chk("press_edge_pre", data_read, 32'h0);
        chk("press_irq_pre", {31'b0, irq}, 32'h0);
        tick(1'b1, 1'b0, 2'd2, 32'h0);
        chk("press_edge", data_read, 32'h2);
        chk("press_irq", {31'b0, irq}, 32'h1);
        tick(1'b1, 1'b1, 2'd2, 32'h2);
        chk("clear_read_preclear", data_read, 32'h2);
        tick(1'b1, 1'b0, 2'd2, 32'h0);
        chk("clear_edge", data_read, 32'h0);
        chk("clear_irq", {31'b0, irq}, 32'h0);
        key = 4'hF;
        repeat (8) tick(1'b1, 1'b0, 2'd2, 32'h0);
        chk("release_no_edge", data_read, 32'h0);

        key = 4'b1110;
        repeat (5) tick(1'b1, 1'b0, 2'd1, 32'h0);
        tick(1'b1, 1'b1, 2'd2, 32'h1);
        tick(1'b1, 1'b0, 2'd2, 32'h0);
        chk("set_beats_clear", data_read, 32'h1);
        key = 4'hF;
        repeat (8) tick(1'b1, 1'b0, 2'd0, 32'h0);

        sw = 10'h3FF;
        repeat (4) tick(1'b1, 1'b0, 2'd0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_data_read", data_read, 32'h0);
        chk("midreset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (6) tick(1'b1, 1'b0, 2'd0, 32'h0);
        chk("relatency_before", data_read, 32'h0);
        tick(1'b1, 1'b0, 2'd0, 32'h0);
        chk("relatency_after", data_read, 32'h3FF);

        tick(1'b1, 1'b1, 2'd0, 32'hFFFFFFFF);
        tick(1'b1, 1'b1, 2'd1, 32'hFFFFFFFF);
        tick(1'b1, 1'b1, 2'd3, 32'hF);
        tick(1'b1, 1'b0, 2'd3, 32'h0);
        chk("mask_readback", data_read, 32'hF);
        tick(1'b1, 1'b0, 2'd0, 32'h0);
        chk("sw_unwritable", data_read, 32'h3FF);
        tick(1'b1, 1'b0, 2'd1, 32'h0);
        chk("key_unwritable", data_read, 32'h0);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, 9);
                sw[b] = ~sw[b];
            end
            if ($urandom_range(0, 4) == 0) begin
                b = $urandom_range(0, 3);
                key[b] = ~key[b];
            end
            if (c == 700) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                #2 reset_n = 1'b1;
            end
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), $urandom);
        end
        repeat (4) tick(1'b0, 1'b0, 2'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
